decode_ctrl_stage: RTL and testbench

- Decode stage of the 3-stage hazard-aware RV32I core.
- Consumes the fetched 32-bit instruction and produces the 3-bit ALU operation encoding, operand-source select, immediate, register indices and control strobes.
- Outputs are registered into the ID/EX pipeline register and feed the ALU directly.
- Honours stall and flush requests from the hazard unit and keeps a saturating count of illegal instructions.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/ctrl_decoder.sv | 99 +++++++++
 rtl/decode_ctrl_stage.sv | 109 ++++++++++
 tb/tb_decode_ctrl_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the RV32I core: ALU operation codes, base opcodes and the
// ID/EX control bundle that travels from decode into execute.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        alu_op_e    alu_cntrl;
        logic       alu_src_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // funct3 values shared by the R-type and I-type ALU groups.
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) ||
               (f3 == 3'b100) || (f3 == 3'b010);
    endfunction

    function automatic alu_op_e alu_f3_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational RV32I subset decoder: instruction word to control bundle,
// sign-extended immediate and an illegal-instruction flag.
module ctrl_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o,
    output logic [31:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_type;
    logic [31:0] imm_s_type;
    logic [31:0] imm_b_type;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        ctrl_o    = CTRL_NOP;
        illegal_o = 1'b1;
        imm_o     = '0;

        case (opcode)
            OP_R: begin
                if ((funct3 == 3'b000) && (funct7 == 7'b0100000)) begin
                    illegal_o        = 1'b0;
                    ctrl_o.alu_cntrl = ALU_SUB;
                end else if ((funct7 == 7'b0000000) && alu_f3_legal(funct3)) begin
                    illegal_o        = 1'b0;
                    ctrl_o.alu_cntrl = alu_f3_op(funct3);
                end
                if (!illegal_o) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.rs1       = instr_i[19:15];
                    ctrl_o.rs2       = instr_i[24:20];
                    ctrl_o.rd        = instr_i[11:7];
                end
            end
            OP_I: begin
                if (alu_f3_legal(funct3)) begin
                    illegal_o          = 1'b0;
                    ctrl_o.alu_cntrl   = alu_f3_op(funct3);
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.rs1         = instr_i[19:15];
                    ctrl_o.rd          = instr_i[11:7];
                    imm_o              = imm_i_type;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    illegal_o          = 1'b0;
                    ctrl_o.alu_cntrl   = ALU_ADD;
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.reg_write   = 1'b1;
                    ctrl_o.mem_read    = 1'b1;
                    ctrl_o.rs1         = instr_i[19:15];
                    ctrl_o.rd          = instr_i[11:7];
                    imm_o              = imm_i_type;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    illegal_o          = 1'b0;
                    ctrl_o.alu_cntrl   = ALU_ADD;
                    ctrl_o.alu_src_imm = 1'b1;
                    ctrl_o.mem_write   = 1'b1;
                    ctrl_o.rs1         = instr_i[19:15];
                    ctrl_o.rs2         = instr_i[24:20];
                    imm_o              = imm_s_type;
                end
            end
            OP_BRANCH: begin
                // BEQ compares via SUB; the ALU zero flag resolves it in EX.
                if (funct3 == 3'b000) begin
                    illegal_o        = 1'b0;
                    ctrl_o.alu_cntrl = ALU_SUB;
                    ctrl_o.branch    = 1'b1;
                    ctrl_o.rs1       = instr_i[19:15];
                    ctrl_o.rs2       = instr_i[24:20];
                    imm_o            = imm_b_type;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode stage: registers decoded control into the ID/EX register under
// flush/stall control and keeps a saturating illegal-instruction count.
module decode_ctrl_stage
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [2:0]       alu_cntrl_o,
    output logic             alu_src_imm_o,
    output logic [31:0]      imm_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             branch_o,
    output logic             ex_valid_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [31:0]      dec_imm;

    ctrl_t            ctrl_d,     ctrl_q;
    logic [31:0]      imm_d,      imm_q;
    logic             ex_valid_d, ex_valid_q;
    logic             illegal_d,  illegal_q;
    logic [CNT_W-1:0] cnt_d,      cnt_q;

    ctrl_decoder u_ctrl_decoder (
        .instr_i   (instr_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .imm_o     (dec_imm)
    );

    // Priority below reset: flush, then stall, then load (valid or bubble).
    always_comb begin
        ctrl_d     = ctrl_q;
        imm_d      = imm_q;
        ex_valid_d = ex_valid_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;

        if (flush_i) begin
            ctrl_d     = CTRL_NOP;
            imm_d      = '0;
            ex_valid_d = 1'b0;
            illegal_d  = 1'b0;
        end else if (!stall_i) begin
            if (instr_valid_i) begin
                ctrl_d     = dec_ctrl;
                imm_d      = dec_imm;
                ex_valid_d = 1'b1;
                illegal_d  = dec_illegal;
                if (dec_illegal && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ctrl_d     = CTRL_NOP;
                imm_d      = '0;
                ex_valid_d = 1'b0;
                illegal_d  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= CTRL_NOP;
            imm_q      <= '0;
            ex_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            imm_q      <= imm_d;
            ex_valid_q <= ex_valid_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_cntrl_o   = ctrl_q.alu_cntrl;
    assign alu_src_imm_o = ctrl_q.alu_src_imm;
    assign imm_o         = imm_q;
    assign rs1_o         = ctrl_q.rs1;
    assign rs2_o         = ctrl_q.rs2;
    assign rd_o          = ctrl_q.rd;
    assign reg_write_o   = ctrl_q.reg_write;
    assign mem_read_o    = ctrl_q.mem_read;
    assign mem_write_o   = ctrl_q.mem_write;
    assign branch_o      = ctrl_q.branch;
    assign ex_valid_o    = ex_valid_q;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: directed vectors push hand-computed
// expectations; a monitor pops and compares one entry per registered cycle.
module tb_decode_ctrl_stage;

    typedef struct packed {
        logic [2:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        exv;
        logic        ill;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;

    logic [2:0]  alu_cntrl_o;
    logic        alu_src_imm_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_o;
    logic        ex_valid_o, illegal_o;
    logic [15:0] illegal_cnt_o;

    logic [2:0]  s_alu;
    logic        s_src;
    logic [31:0] s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_rw, s_mr, s_mw, s_br, s_exv, s_ill;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    exp_t  sb_q[$];
    string nm_q[$];

    always #5 clk = ~clk;

    decode_ctrl_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .alu_cntrl_o(alu_cntrl_o), .alu_src_imm_o(alu_src_imm_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .branch_o(branch_o),
        .ex_valid_o(ex_valid_o), .illegal_o(illegal_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    decode_ctrl_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .alu_cntrl_o(s_alu), .alu_src_imm_o(s_src), .imm_o(s_imm),
        .rs1_o(s_rs1), .rs2_o(s_rs2), .rd_o(s_rd),
        .reg_write_o(s_rw), .mem_read_o(s_mr),
        .mem_write_o(s_mw), .branch_o(s_br),
        .ex_valid_o(s_exv), .illegal_o(s_ill),
        .illegal_cnt_o(s_cnt)
    );

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] alu, input logic src, input logic [31:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic mw, input logic br,
                                input logic exv, input logic ill,
                                input logic [15:0] cnt, input logic [1:0] cnt2);
        exp_t e;
        e.alu = alu; e.src = src; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.exv = exv; e.ill = ill;
        e.cnt = cnt; e.cnt2 = cnt2;
        return e;
    endfunction

    function automatic exp_t bubble(input logic [15:0] cnt, input logic [1:0] cnt2);
        return mk(3'b000, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, cnt, cnt2);
    endfunction

    function automatic exp_t ill_exp(input logic [15:0] cnt, input logic [1:0] cnt2);
        return mk(3'b000, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, cnt, cnt2);
    endfunction

    // Drive one cycle of inputs and queue what the register must hold after the next edge.
    task automatic step(input string nm, input logic r, input logic v, input logic s,
                        input logic f, input logic [31:0] ins, input exp_t e);
        @(posedge clk);
        #2;
        rst = r; instr_valid_i = v; stall_i = s; flush_i = f; instr_i = ins;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n = nm_q.pop_front();
                check({n, ".alu"},  {29'd0, alu_cntrl_o},   {29'd0, e.alu});
                check({n, ".src"},  {31'd0, alu_src_imm_o}, {31'd0, e.src});
                check({n, ".imm"},  imm_o,                  e.imm);
                check({n, ".rs1"},  {27'd0, rs1_o},         {27'd0, e.rs1});
                check({n, ".rs2"},  {27'd0, rs2_o},         {27'd0, e.rs2});
                check({n, ".rd"},   {27'd0, rd_o},          {27'd0, e.rd});
                check({n, ".strb"}, {28'd0, reg_write_o, mem_read_o, mem_write_o, branch_o},
                                    {28'd0, e.rw, e.mr, e.mw, e.br});
                check({n, ".exv"},  {31'd0, ex_valid_o},    {31'd0, e.exv});
                check({n, ".ill"},  {31'd0, illegal_o},     {31'd0, e.ill});
                check({n, ".cnt"},  {16'd0, illegal_cnt_o}, {16'd0, e.cnt});
                check({n, ".cnt2"}, {30'd0, s_cnt},         {30'd0, e.cnt2});
            end
        end
    end

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_LW   = 32'h0040A303;
    localparam logic [31:0] I_SW   = 32'h0020A423;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_XOR  = 32'h0020C233;
    localparam logic [31:0] I_SLTI = 32'h0050A393;
    localparam logic [31:0] I_ANDI = 32'hFF017413;
    localparam logic [31:0] I_OR   = 32'h0041E4B3;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_SLLI = 32'h00109093;

    initial begin : stimulus
        exp_t e_add, e_sub;
        e_add = mk(3'b010, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 0, 16'd0, 2'd0);
        e_sub = mk(3'b110, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 0, 16'd0, 2'd0);

        step("reset0", 1, 0, 0, 0, I_ADD, bubble(0, 0));
        step("reset1", 1, 1, 0, 0, I_ADD, bubble(0, 0));

        step("add",  0, 1, 0, 0, I_ADD,  e_add);
        step("sub",  0, 1, 0, 0, I_SUB,  e_sub);
        step("addi", 0, 1, 0, 0, I_ADDI, mk(3'b010, 1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0, 1, 0, 0, 0));
        step("lw",   0, 1, 0, 0, I_LW,   mk(3'b010, 1, 32'd4, 5'd1, 5'd0, 5'd6, 1, 1, 0, 0, 1, 0, 0, 0));
        step("sw",   0, 1, 0, 0, I_SW,   mk(3'b010, 1, 32'd8, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, 1, 0, 0, 0));
        step("beq",  0, 1, 0, 0, I_BEQ,  mk(3'b110, 0, 32'd8, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0));
        step("xor",  0, 1, 0, 0, I_XOR,  mk(3'b011, 0, 32'h0, 5'd1, 5'd2, 5'd4, 1, 0, 0, 0, 1, 0, 0, 0));
        step("slti", 0, 1, 0, 0, I_SLTI, mk(3'b111, 1, 32'd5, 5'd1, 5'd0, 5'd7, 1, 0, 0, 0, 1, 0, 0, 0));
        step("andi", 0, 1, 0, 0, I_ANDI, mk(3'b000, 1, 32'hFFFFFFF0, 5'd2, 5'd0, 5'd8, 1, 0, 0, 0, 1, 0, 0, 0));
        step("or",   0, 1, 0, 0, I_OR,   mk(3'b001, 0, 32'h0, 5'd3, 5'd4, 5'd9, 1, 0, 0, 0, 1, 0, 0, 0));
        step("novalid", 0, 0, 0, 0, I_ADD, bubble(0, 0));

        step("add_pre_stall", 0, 1, 0, 0, I_ADD, e_add);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), 0, 1, 1, 0, I_SUB, e_add);
        end
        step("stall_flush", 0, 1, 1, 1, I_SUB, bubble(0, 0));

        step("bad1", 0, 1, 0, 0, I_BAD, ill_exp(1, 1));
        step("bad2", 0, 1, 0, 0, I_BAD, ill_exp(2, 2));
        step("bad3", 0, 1, 0, 0, I_BAD, ill_exp(3, 3));
        step("bad_flush",   0, 1, 0, 1, I_BAD, bubble(3, 3));
        step("bad_invalid", 0, 0, 0, 0, I_BAD, bubble(3, 3));
        step("bad_stalled", 0, 1, 1, 0, I_BAD, bubble(3, 3));
        step("bad4", 0, 1, 0, 0, I_BAD, ill_exp(4, 3));
        step("bad5", 0, 1, 0, 0, I_BAD, ill_exp(5, 3));
        step("mul",  0, 1, 0, 0, I_MUL,  ill_exp(6, 3));
        step("slli", 0, 1, 0, 0, I_SLLI, ill_exp(7, 3));
        step("ill_hold", 0, 1, 1, 0, I_BAD, ill_exp(7, 3));

        e_sub.cnt = 16'd7; e_sub.cnt2 = 2'd3;
        step("sub_pre_rst", 0, 1, 0, 0, I_SUB, e_sub);
        step("sub_stall",   0, 1, 1, 0, I_ADD, e_sub);
        step("rst_in_stall", 1, 1, 1, 1, I_ADD, bubble(0, 0));
        step("add_post_rst", 0, 1, 0, 0, I_ADD, e_add);

        // Let the monitor drain; a leftover entry means outputs were never compared.
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        check("drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
